sweep_max_ctrl: RTL and testbench



---
 rtl/sweep_max_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_sweep_max_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_max_ctrl.sv
// sweep_max_ctrl: paces servo steps during a sweep, records the ADC
// peak and its step index, then counts back to that peak on request.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   CNT_RST           synchronous clear from the mode FSM
//   HS, VS, MC        horizontal sweep / vertical sweep / max-return enables
//   ADC_DATA/VALID    light sample stream, VALID is a one-cycle strobe
//   CNT_L/CNT_D       horizontal / vertical sweep in progress
//   CNT_RU            return to peak in progress
//   STEP_TICK         one-cycle pulse per servo step
//   MAX_VAL, MAX_POS  peak sample and the step index where it occurred
//   POS               current step index
module sweep_max_ctrl #(
    parameter int STEP_W   = 8,
    parameter int N_STEPS  = 180,
    parameter int STEP_DIV = 1000000,
    parameter int ADC_W    = 12
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CNT_RST,
    input  logic              HS,
    input  logic              VS,
    input  logic              MC,
    input  logic [ADC_W-1:0]  ADC_DATA,
    input  logic              ADC_VALID,
    output logic              CNT_L,
    output logic              CNT_D,
    output logic              CNT_RU,
    output logic              STEP_TICK,
    output logic [ADC_W-1:0]  MAX_VAL,
    output logic [STEP_W-1:0] MAX_POS,
    output logic [STEP_W-1:0] POS
);

    localparam int PW = $clog2(STEP_DIV);
    localparam logic [PW-1:0] DIV_M1 = PW'(STEP_DIV - 1);
    localparam logic [STEP_W-1:0] NST = STEP_W'(N_STEPS);
    localparam logic [STEP_W-1:0] ONE = STEP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE,
        S_RETURN
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              axis_v;
    logic              axis_v_n;
    logic [PW-1:0]     presc;
    logic [STEP_W-1:0] remaining;
    logic [STEP_W-1:0] pos_inc;
    logic              stepping;
    logic              tick;
    logic              sw_abort;
    logic              sw_end;
    logic              rt_end;

    always_comb begin
        pos_inc  = POS + ONE;
        stepping = (state == S_SWEEP) || (state == S_RETURN);
        tick     = stepping && (presc == DIV_M1);
        // the enable that started this sweep is the one that keeps it alive
        sw_abort = (state == S_SWEEP) && (axis_v ? !VS : !HS);
        sw_end   = (state == S_SWEEP) && tick && (pos_inc == NST);
        rt_end   = (state == S_RETURN) && MC && tick
                   && (remaining == ONE);
    end

    assign STEP_TICK = tick;

    always_comb begin
        state_n  = state;
        axis_v_n = axis_v;
        if (CNT_RST) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (HS) begin
                        state_n  = S_SWEEP;
                        axis_v_n = 1'b0;
                    end else if (VS) begin
                        state_n  = S_SWEEP;
                        axis_v_n = 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (sw_abort) begin
                        state_n = S_IDLE;
                    end else if (sw_end) begin
                        state_n = S_DONE;
                    end
                end
                S_DONE: begin
                    if (MC) begin
                        state_n = S_RETURN;
                    end else if (!HS && !VS) begin
                        state_n = S_IDLE;
                    end
                end
                S_RETURN: begin
                    if (!MC || rt_end) begin
                        state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= S_IDLE;
            axis_v <= 1'b0;
        end else begin
            state  <= state_n;
            axis_v <= axis_v_n;
        end
    end

    // Direction outputs are registered from the next state so they are
    // high exactly while the FSM sits in the matching state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CNT_L  <= 1'b0;
            CNT_D  <= 1'b0;
            CNT_RU <= 1'b0;
        end else begin
            CNT_L  <= (state_n == S_SWEEP) && !axis_v_n;
            CNT_D  <= (state_n == S_SWEEP) && axis_v_n;
            CNT_RU <= (state_n == S_RETURN);
        end
    end

    // Prescaler only runs while staying in a stepping state, so every
    // entry into SWEEP/RETURN starts from a zero count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc <= '0;
        end else if (CNT_RST || tick || !stepping
                     || (state_n != state)) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            POS       <= '0;
            MAX_VAL   <= '0;
            MAX_POS   <= '0;
            remaining <= '0;
        end else if (CNT_RST) begin
            POS       <= '0;
            MAX_VAL   <= '0;
            MAX_POS   <= '0;
            remaining <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (state_n == S_SWEEP) begin
                        POS     <= '0;
                        MAX_VAL <= '0;
                        MAX_POS <= '0;
                    end
                end
                S_SWEEP: begin
                    // strict compare: first occurrence of the peak wins,
                    // and the pre-increment POS is recorded on a tick
                    if (ADC_VALID && (ADC_DATA > MAX_VAL)) begin
                        MAX_VAL <= ADC_DATA;
                        MAX_POS <= POS;
                    end
                    if (tick && !sw_abort && (POS != NST)) begin
                        POS <= pos_inc;
                    end
                end
                S_DONE: begin
                    if (state_n == S_RETURN) begin
                        remaining <= NST - MAX_POS;
                    end
                end
                S_RETURN: begin
                    if (MC && tick) begin
                        if (POS != '0) begin
                            POS <= POS - ONE;
                        end
                        remaining <= remaining - ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_max_ctrl.sv
// tb_sweep_max_ctrl: directed bench for sweep_max_ctrl with 8 steps per
// sweep and 4 clocks per step.
module tb_sweep_max_ctrl;

    localparam int SW = 8;
    localparam int AW = 12;

    logic          CLK;
    logic          RST_N;
    logic          CNT_RST;
    logic          HS;
    logic          VS;
    logic          MC;
    logic [AW-1:0] ADC_DATA;
    logic          ADC_VALID;
    logic          CNT_L;
    logic          CNT_D;
    logic          CNT_RU;
    logic          STEP_TICK;
    logic [AW-1:0] MAX_VAL;
    logic [SW-1:0] MAX_POS;
    logic [SW-1:0] POS;

    int total = 0;
    int bad   = 0;
    int lcnt  = 0;
    int dcnt  = 0;
    int rucnt = 0;
    int tcnt  = 0;
    int l0, d0, r0, t0;

    sweep_max_ctrl #(
        .STEP_W  (SW),
        .N_STEPS (8),
        .STEP_DIV(4),
        .ADC_W   (AW)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CNT_RST  (CNT_RST),
        .HS       (HS),
        .VS       (VS),
        .MC       (MC),
        .ADC_DATA (ADC_DATA),
        .ADC_VALID(ADC_VALID),
        .CNT_L    (CNT_L),
        .CNT_D    (CNT_D),
        .CNT_RU   (CNT_RU),
        .STEP_TICK(STEP_TICK),
        .MAX_VAL  (MAX_VAL),
        .MAX_POS  (MAX_POS),
        .POS      (POS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (CNT_L) lcnt++;
        if (CNT_D) dcnt++;
        if (CNT_RU) rucnt++;
        if (STEP_TICK) tcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expire(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return CNT_L;
            1:       return CNT_D;
            default: return CNT_RU;
        endcase
    endfunction

    task automatic wait_pos(input logic [SW-1:0] p, input int budget);
        int n = 0;
        while (POS !== p && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (POS !== p) expire("wait_pos");
    endtask

    task automatic wait_low(input int sel, input int budget);
        int n = 0;
        while (sel_sig(sel) !== 1'b0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (sel_sig(sel) !== 1'b0) expire("wait_low");
    endtask

    task automatic pulse(input logic [AW-1:0] d);
        ADC_DATA  = d;
        ADC_VALID = 1'b1;
        @(negedge CLK);
        ADC_VALID = 1'b0;
        ADC_DATA  = '0;
    endtask

    initial begin
        int n;
        RST_N     = 1'b0;
        CNT_RST   = 1'b0;
        HS        = 1'b0;
        VS        = 1'b0;
        MC        = 1'b0;
        ADC_DATA  = '0;
        ADC_VALID = 1'b0;
        #12;
        chk("rst_cnt_l", 32'(CNT_L), 0);
        chk("rst_cnt_d", 32'(CNT_D), 0);
        chk("rst_cnt_ru", 32'(CNT_RU), 0);
        chk("rst_tick", 32'(STEP_TICK), 0);
        chk("rst_max_val", 32'(MAX_VAL), 0);
        chk("rst_max_pos", 32'(MAX_POS), 0);
        chk("rst_pos", 32'(POS), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // horizontal sweep, peak 50 at step 3
        l0 = lcnt;
        t0 = tcnt;
        HS = 1'b1;
        @(negedge CLK);
        chk("a_cnt_l_on", 32'(CNT_L), 1);
        chk("a_pos_start", 32'(POS), 0);
        wait_pos(8'd1, 20);
        pulse(12'd10);
        wait_pos(8'd3, 20);
        pulse(12'd50);
        wait_pos(8'd5, 20);
        pulse(12'd30);
        wait_low(0, 60);
        chk("a_cnt_l_cycles", 32'(lcnt - l0), 32);
        chk("a_ticks", 32'(tcnt - t0), 8);
        chk("a_max_val", 32'(MAX_VAL), 50);
        chk("a_max_pos", 32'(MAX_POS), 3);
        chk("a_pos_end", 32'(POS), 8);
        chk("a_cnt_d_off", 32'(CNT_D), 0);

        // return to step 3
        r0 = rucnt;
        t0 = tcnt;
        HS = 1'b0;
        MC = 1'b1;
        @(negedge CLK);
        chk("a_ru_on", 32'(CNT_RU), 1);
        chk("a_ru_cnt_l_off", 32'(CNT_L), 0);
        wait_low(2, 60);
        chk("a_ru_cycles", 32'(rucnt - r0), 20);
        chk("a_ru_ticks", 32'(tcnt - t0), 5);
        chk("a_ru_pos", 32'(POS), 3);
        chk("a_ru_max_pos", 32'(MAX_POS), 3);

        // vertical sweep with equal samples, first one wins
        MC = 1'b0;
        VS = 1'b1;
        d0 = dcnt;
        @(negedge CLK);
        chk("b_cnt_d_on", 32'(CNT_D), 1);
        chk("b_cnt_l_off", 32'(CNT_L), 0);
        chk("b_max_val_clr", 32'(MAX_VAL), 0);
        chk("b_max_pos_clr", 32'(MAX_POS), 0);
        chk("b_pos_start", 32'(POS), 0);
        wait_pos(8'd2, 20);
        pulse(12'd40);
        wait_pos(8'd6, 30);
        pulse(12'd40);
        wait_low(1, 60);
        chk("b_cnt_d_cycles", 32'(dcnt - d0), 32);
        chk("b_max_val", 32'(MAX_VAL), 40);
        chk("b_max_pos", 32'(MAX_POS), 2);
        chk("b_pos_end", 32'(POS), 8);

        // asynchronous reset in the middle of the return
        VS = 1'b0;
        MC = 1'b1;
        @(negedge CLK);
        chk("b_ru_on", 32'(CNT_RU), 1);
        wait_pos(8'd6, 20);
        #2;
        RST_N = 1'b0;
        #1;
        chk("b_arst_ru", 32'(CNT_RU), 0);
        chk("b_arst_pos", 32'(POS), 0);
        chk("b_arst_max_val", 32'(MAX_VAL), 0);
        chk("b_arst_max_pos", 32'(MAX_POS), 0);
        chk("b_arst_tick", 32'(STEP_TICK), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        MC    = 1'b0;
        HS    = 1'b1;
        @(negedge CLK);
        chk("c_cnt_l_on", 32'(CNT_L), 1);
        chk("c_pos_start", 32'(POS), 0);

        // sample coinciding with the step tick at step 4
        n = 0;
        while (!(POS === 8'd4 && STEP_TICK === 1'b1) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (!(POS === 8'd4 && STEP_TICK === 1'b1)) expire("c_wait_tick4");
        pulse(12'd20);
        chk("c_tick_max_pos", 32'(MAX_POS), 4);
        chk("c_tick_max_val", 32'(MAX_VAL), 20);
        chk("c_tick_pos", 32'(POS), 5);

        // synchronous clear at step 5, then held with HS high
        CNT_RST = 1'b1;
        @(negedge CLK);
        chk("c_clr_cnt_l", 32'(CNT_L), 0);
        chk("c_clr_pos", 32'(POS), 0);
        chk("c_clr_max_val", 32'(MAX_VAL), 0);
        chk("c_clr_max_pos", 32'(MAX_POS), 0);
        @(negedge CLK);
        chk("c_hold_cnt_l", 32'(CNT_L), 0);
        chk("c_hold_tick", 32'(STEP_TICK), 0);

        // sweep with no samples, full-length return
        l0 = lcnt;
        t0 = tcnt;
        CNT_RST = 1'b0;
        @(negedge CLK);
        chk("d_cnt_l_on", 32'(CNT_L), 1);
        chk("d_pos_start", 32'(POS), 0);
        wait_low(0, 60);
        chk("d_cnt_l_cycles", 32'(lcnt - l0), 32);
        chk("d_ticks", 32'(tcnt - t0), 8);
        chk("d_max_val", 32'(MAX_VAL), 0);
        chk("d_max_pos", 32'(MAX_POS), 0);
        chk("d_pos_end", 32'(POS), 8);
        r0 = rucnt;
        t0 = tcnt;
        HS = 1'b0;
        MC = 1'b1;
        @(negedge CLK);
        chk("d_ru_on", 32'(CNT_RU), 1);
        wait_low(2, 80);
        chk("d_ru_cycles", 32'(rucnt - r0), 32);
        chk("d_ru_ticks", 32'(tcnt - t0), 8);
        chk("d_ru_pos", 32'(POS), 0);
        MC = 1'b0;
        @(negedge CLK);
        chk("end_cnt_l", 32'(CNT_L), 0);
        chk("end_cnt_d", 32'(CNT_D), 0);
        chk("end_cnt_ru", 32'(CNT_RU), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
